lsu_dbus_adapter: RTL and testbench
===================================

Name: lsu_dbus_adapter

Overview:
- Per-core adapter between a core's load/store unit and the multi-core data bus arbiter; one instance per core, and the NCORES copies are concatenated into the arbiter's packed ports.
- Accepts one LSU request at a time over a valid/ready handshake and checks alignment.
- Converts byte/half/word accesses into a word-aligned bus request with byte strobes; LR/SC flags pass through.
- Waits out the bus stall, then returns a sign/zero-extended load result, the SC status or an error code.

Parameters:
TIMEOUT_CYCLES, 1024, max WAIT cycles before error; 0 disables timeout
TO_WIDTH, 11, width of timeout counter (>= clog2(TIMEOUT_CYCLES+1))

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
req_valid_i  in  1  LSU request valid
req_ready_o  out  1  adapter can accept (high only in IDLE)
req_we_i  in  1  1=store/SC, 0=load/LR
req_addr_i  in  32  byte address
req_wdata_i  in  32  store data, LSB-justified
req_size_i  in  2  0=byte 1=half 2=word (3 illegal→misaligned error)
req_unsigned_i  in  1  zero-extend load
req_lr_i  in  1  load-reserved
req_sc_i  in  1  store-conditional
resp_valid_o  out  1  one-cycle response pulse
resp_data_o  out  32  load data / SC status (0=success) / 0 for stores and errors
resp_err_o  out  2  0=ok 1=misaligned 2=null-region 3=timeout
re_o  out  1  bus read enable
we_o  out  1  bus write enable
addr_o  out  32  bus address {req_addr[31:2],2'b00}; 0 means no request
wdata_o  out  32  lane-replicated store data
wstrb_o  out  4  byte strobes
is_lr_o  out  1  LR flag
is_sc_o  out  1  SC flag
rdata_i  in  32  bus read data, valid in the completion cycle
stall_i  in  1  bus busy

Behaviour:
- Bus contract: a request is a single cycle with addr_o != 0. stall_i is high from the cycle after issue until completion. Completion is the first subsequent cycle with stall_i=0; rdata_i is valid in that cycle.
- All outputs are registered. Reset value of every output is 0, except req_ready_o=1. State resets to IDLE and the timeout counter to 0. Reset mid-transaction abandons it with no response.
- States: IDLE, ISSUE, WAIT, DRAIN.
- IDLE: req_ready_o=1. On req_valid_i, latch the request and check it; checks are prioritised in the order listed:
  - misaligned (half with addr[0]=1; word/LR/SC with addr[1:0]!=0; size=3; LR/SC with size!=2) → resp_valid_o=1, err=1 next cycle, no bus access, stay IDLE;
  - else addr<4 → err=2, same as above;
  - else → ISSUE.
- ISSUE: drive the bus outputs for exactly one cycle:
  - re_o=!we, we_o=we, is_lr_o/is_sc_o as latched;
  - wstrb_o: byte = 4'b0001<<addr[1:0]; half = 4'b0011<<{addr[1],1'b0}; word = 4'b1111;
  - wdata_o: byte = {4{wdata[7:0]}}; half = {2{wdata[15:0]}}; word as-is.
  - Next state WAIT; counter cleared.
- WAIT: bus outputs 0, counter increments each cycle.
  - stall_i=0 → response next cycle and return to IDLE. Load: lane = rdata_i >> (8*addr[1:0]), truncated to size, sign- or zero-extended. SC: resp_data_o = rdata_i. Store: resp_data_o = 0. err=0.
  - Counter reaches TIMEOUT_CYCLES (TIMEOUT_CYCLES≠0) with stall_i high → response err=3, data 0, then DRAIN.
  - stall_i=0 in the same cycle as the timeout → the completion wins.
- DRAIN: req_ready_o=0; wait for stall_i=0, discard rdata_i, then IDLE with no further response.
- resp_valid_o is high exactly one cycle per accepted request, except a request abandoned by reset. A new request is accepted in the same cycle resp_valid_o is high (back-to-back); minimum accept-to-accept spacing is 3 cycles for bus accesses and 1 cycle for error requests.
- Request inputs are sampled only when req_valid_i && req_ready_o; changes at other times are ignored.
- Counter saturates and does not wrap.

Decomposition:
- Shared include dbus_defs.vh: size codes (SZ_BYTE/HALF/WORD), error codes (ERR_OK/MISALIGN/NULL/TIMEOUT), state encodings.
- Sub-module lsu_data_align (combinational): store lane replication and strobe generation, plus load lane extraction and extension. Reusable by the arbiter's bench model.

Test Plan:
- Word load: addr 0x100, rdata_i=0xDEADBEEF after 3 stall cycles → bus addr_o=0x100, re_o=1 for one cycle; resp_data_o=0xDEADBEEF, err=0, exactly one pulse.
- Byte signed/unsigned load: addr 0x103, rdata_i=0x80xxxxxx → signed 0xFFFFFF80; unsigned 0x00000080.
- Half store: addr 0x102, wdata 0x1234ABCD → wstrb_o=4'b1100, wdata_o=0xABCDABCD, addr_o=0x100; response data 0.
- Errors: word at 0x101 → err=1 next cycle, no bus activity; byte at 0x2 → err=2; size=3 → err=1.
- SC/LR: LR 0x200 then SC 0x200, bus returns 0 → is_lr_o/is_sc_o pulsed, SC resp_data_o=0; SC with size=0 → err=1.
- Timeout and reset: TIMEOUT_CYCLES=8, stall held 20 cycles → err=3 after 8 WAIT cycles, req_ready_o low until stall drops, no second response. Reset asserted during WAIT → outputs 0, req_ready_o=1 next cycle.

Source files
------------

// File: rtl/lsu_dbus_adapter_pkg.sv
// Shared definitions for the LSU-to-data-bus adapter: size/error codes, FSM states, latched request.
// Latency: n/a (types, constants and one pure helper function).
// Backpressure: n/a.
package lsu_dbus_adapter_pkg;

    // Access size codes as driven by the LSU
    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    // Response error codes
    localparam logic [1:0] ERR_OK       = 2'd0;
    localparam logic [1:0] ERR_MISALIGN = 2'd1;
    localparam logic [1:0] ERR_NULL     = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

    // Only the fields still needed after the bus request has been issued
    typedef struct packed {
        logic       we;
        logic       sc;
        logic       uns;
        logic [1:0] size;
        logic [1:0] addr_lo;
    } req_t;

    // Request legality; misalignment outranks the null-region check
    function automatic logic [1:0] check_req(input logic [31:0] addr, input logic [1:0] size,
                                             input logic lr, input logic sc);
        logic       mis;
        logic [1:0] res;
        mis = (size == 2'd3)
           || ((size == SZ_HALF) && addr[0])
           || ((size == SZ_WORD) && (addr[1:0] != 2'b00))
           || ((lr || sc) && ((size != SZ_WORD) || (addr[1:0] != 2'b00)));
        if (mis)
            res = ERR_MISALIGN;
        else if (addr < 32'd4)
            res = ERR_NULL;
        else
            res = ERR_OK;
        return res;
    endfunction

endpackage

// File: rtl/lsu_dbus_adapter_data_align.sv
// Byte-lane steering: store replication + strobes, load lane extraction + sign/zero extension.
// Latency: purely combinational.
// Backpressure: none; callers qualify inputs and outputs.
module lsu_data_align
    import lsu_dbus_adapter_pkg::*;
(
    input  logic [1:0]  i_addr_lo,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [31:0] o_wdata,
    output logic [3:0]  o_wstrb,
    output logic [31:0] o_rdata
);

    logic [31:0] w_lane;

    assign w_lane = i_rdata >> {i_addr_lo, 3'b000};

    // Store path: replicate the LSB-justified data into every lane, strobe the addressed ones
    always_comb begin
        o_wdata = i_wdata;
        o_wstrb = 4'b1111;
        case (i_size)
            SZ_BYTE: begin
                o_wdata = {4{i_wdata[7:0]}};
                o_wstrb = 4'b0001 << i_addr_lo;
            end
            SZ_HALF: begin
                o_wdata = {2{i_wdata[15:0]}};
                o_wstrb = 4'b0011 << {i_addr_lo[1], 1'b0};
            end
            default: begin
                o_wdata = i_wdata;
                o_wstrb = 4'b1111;
            end
        endcase
    end

    // Load path: shift the addressed lane down, truncate to size, extend
    always_comb begin
        o_rdata = w_lane;
        case (i_size)
            SZ_BYTE: o_rdata = {{24{w_lane[7] & ~i_unsigned}}, w_lane[7:0]};
            SZ_HALF: o_rdata = {{16{w_lane[15] & ~i_unsigned}}, w_lane[15:0]};
            default: o_rdata = w_lane;
        endcase
    end

endmodule

// File: rtl/lsu_dbus_adapter.sv
// Per-core LSU-to-data-bus adapter: alignment check, single-cycle bus issue, stall wait, extended response.
// Latency: error response 1 cycle after accept; bus access >= 3 cycles accept-to-response (issue, wait, respond).
// Backpressure: one request in flight; req_ready_o high only in IDLE, low through issue, wait and timeout drain.
module lsu_dbus_adapter
    import lsu_dbus_adapter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned TO_WIDTH       = 11
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_unsigned_i,
    input  logic        req_lr_i,
    input  logic        req_sc_i,
    output logic        resp_valid_o,
    output logic [31:0] resp_data_o,
    output logic [1:0]  resp_err_o,
    output logic        re_o,
    output logic        we_o,
    output logic [31:0] addr_o,
    output logic [31:0] wdata_o,
    output logic [3:0]  wstrb_o,
    output logic        is_lr_o,
    output logic        is_sc_o,
    input  logic [31:0] rdata_i,
    input  logic        stall_i
);

    // Counter value at which the current stalled WAIT cycle is the last one allowed
    localparam logic [TO_WIDTH-1:0] TO_LAST =
        TO_WIDTH'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    state_e              r_state;
    state_e              w_state_nxt;
    req_t                r_req;
    logic [TO_WIDTH-1:0] r_cnt;

    logic        r_req_ready;
    logic        r_resp_valid;
    logic [31:0] r_resp_data;
    logic [1:0]  r_resp_err;
    logic        r_re;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic        r_is_lr;
    logic        r_is_sc;

    logic        w_resp_valid_nxt;
    logic [31:0] w_resp_data_nxt;
    logic [1:0]  w_resp_err_nxt;
    logic        w_re_nxt;
    logic        w_we_nxt;
    logic [31:0] w_addr_nxt;
    logic [31:0] w_wdata_nxt;
    logic [3:0]  w_wstrb_nxt;
    logic        w_is_lr_nxt;
    logic        w_is_sc_nxt;

    logic        w_accept;
    logic [1:0]  w_chk;
    logic        w_timeout;
    logic [1:0]  w_al_addr;
    logic [1:0]  w_al_size;
    logic [31:0] w_al_wdata;
    logic [3:0]  w_al_wstrb;
    logic [31:0] w_al_rdata;

    assign w_accept  = req_valid_i && r_req_ready && (r_state == ST_IDLE);
    assign w_chk     = check_req(req_addr_i, req_size_i, req_lr_i, req_sc_i);
    assign w_timeout = (TIMEOUT_CYCLES != 0) && stall_i && (r_cnt == TO_LAST);

    // In IDLE the aligner steers the incoming store; afterwards it extracts the latched load lane
    assign w_al_addr = (r_state == ST_IDLE) ? req_addr_i[1:0] : r_req.addr_lo;
    assign w_al_size = (r_state == ST_IDLE) ? req_size_i      : r_req.size;

    lsu_data_align u_align (
        .i_addr_lo  (w_al_addr),
        .i_size     (w_al_size),
        .i_unsigned (r_req.uns),
        .i_wdata    (req_wdata_i),
        .i_rdata    (rdata_i),
        .o_wdata    (w_al_wdata),
        .o_wstrb    (w_al_wstrb),
        .o_rdata    (w_al_rdata)
    );

    // State register and request latch
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_req   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_req.we      <= req_we_i;
                r_req.sc      <= req_sc_i;
                r_req.uns     <= req_unsigned_i;
                r_req.size    <= req_size_i;
                r_req.addr_lo <= req_addr_i[1:0];
            end
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept && (w_chk == ERR_OK)) w_state_nxt = ST_ISSUE;
            ST_ISSUE: w_state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (!stall_i)
                    w_state_nxt = ST_IDLE;
                else if (w_timeout)
                    w_state_nxt = ST_DRAIN;
            end
            ST_DRAIN: if (!stall_i) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs
    always_comb begin
        w_resp_valid_nxt = 1'b0;
        w_resp_data_nxt  = '0;
        w_resp_err_nxt   = ERR_OK;
        w_re_nxt         = 1'b0;
        w_we_nxt         = 1'b0;
        w_addr_nxt       = '0;
        w_wdata_nxt      = '0;
        w_wstrb_nxt      = '0;
        w_is_lr_nxt      = 1'b0;
        w_is_sc_nxt      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_chk != ERR_OK) begin
                        w_resp_valid_nxt = 1'b1;
                        w_resp_err_nxt   = w_chk;
                    end else begin
                        w_re_nxt    = !req_we_i;
                        w_we_nxt    = req_we_i;
                        w_addr_nxt  = {req_addr_i[31:2], 2'b00};
                        w_wdata_nxt = w_al_wdata;
                        w_wstrb_nxt = w_al_wstrb;
                        w_is_lr_nxt = req_lr_i;
                        w_is_sc_nxt = req_sc_i;
                    end
                end
            end
            ST_WAIT: begin
                // Completion takes precedence over a coincident timeout
                if (!stall_i) begin
                    w_resp_valid_nxt = 1'b1;
                    if (r_req.sc)
                        w_resp_data_nxt = rdata_i;
                    else if (r_req.we)
                        w_resp_data_nxt = '0;
                    else
                        w_resp_data_nxt = w_al_rdata;
                end else if (w_timeout) begin
                    w_resp_valid_nxt = 1'b1;
                    w_resp_err_nxt   = ERR_TIMEOUT;
                end
            end
            default: ;
        endcase
    end

    // Output registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_data  <= '0;
            r_resp_err   <= ERR_OK;
            r_re         <= 1'b0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_wstrb      <= '0;
            r_is_lr      <= 1'b0;
            r_is_sc      <= 1'b0;
        end else begin
            r_req_ready  <= (w_state_nxt == ST_IDLE);
            r_resp_valid <= w_resp_valid_nxt;
            r_resp_data  <= w_resp_data_nxt;
            r_resp_err   <= w_resp_err_nxt;
            r_re         <= w_re_nxt;
            r_we         <= w_we_nxt;
            r_addr       <= w_addr_nxt;
            r_wdata      <= w_wdata_nxt;
            r_wstrb      <= w_wstrb_nxt;
            r_is_lr      <= w_is_lr_nxt;
            r_is_sc      <= w_is_sc_nxt;
        end
    end

    // Stall-cycle counter: cleared on issue, saturating increment while waiting
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt <= '0;
        end else if (r_state == ST_ISSUE) begin
            r_cnt <= '0;
        end else if ((r_state == ST_WAIT) && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign req_ready_o  = r_req_ready;
    assign resp_valid_o = r_resp_valid;
    assign resp_data_o  = r_resp_data;
    assign resp_err_o   = r_resp_err;
    assign re_o         = r_re;
    assign we_o         = r_we;
    assign addr_o       = r_addr;
    assign wdata_o      = r_wdata;
    assign wstrb_o      = r_wstrb;
    assign is_lr_o      = r_is_lr;
    assign is_sc_o      = r_is_sc;

endmodule

// File: tb/tb_lsu_dbus_adapter.sv
// Scoreboard bench for lsu_dbus_adapter: directed requests, modelled bus stall, queued expectations.
// Latency: response latency checked against hand-computed cycle counts.
// Backpressure: request driver waits on req_ready_o with a bounded loop.
module tb_lsu_dbus_adapter;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  err;
        int          acc_cyc;
        int          lat;
        string       name;
    } exp_resp_t;

    typedef struct {
        logic        re;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        lr;
        logic        sc;
        string       name;
    } exp_bus_t;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic        req_we_i = 1'b0;
    logic [31:0] req_addr_i = '0;
    logic [31:0] req_wdata_i = '0;
    logic [1:0]  req_size_i = '0;
    logic        req_unsigned_i = 1'b0;
    logic        req_lr_i = 1'b0;
    logic        req_sc_i = 1'b0;
    logic        resp_valid_o;
    logic [31:0] resp_data_o;
    logic [1:0]  resp_err_o;
    logic        re_o;
    logic        we_o;
    logic [31:0] addr_o;
    logic [31:0] wdata_o;
    logic [3:0]  wstrb_o;
    logic        is_lr_o;
    logic        is_sc_o;
    logic [31:0] rdata_i = '0;
    logic        stall_i = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    exp_resp_t resp_q[$];
    exp_bus_t  bus_q[$];

    lsu_dbus_adapter #(.TIMEOUT_CYCLES(8), .TO_WIDTH(4)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_we_i       (req_we_i),
        .req_addr_i     (req_addr_i),
        .req_wdata_i    (req_wdata_i),
        .req_size_i     (req_size_i),
        .req_unsigned_i (req_unsigned_i),
        .req_lr_i       (req_lr_i),
        .req_sc_i       (req_sc_i),
        .resp_valid_o   (resp_valid_o),
        .resp_data_o    (resp_data_o),
        .resp_err_o     (resp_err_o),
        .re_o           (re_o),
        .we_o           (we_o),
        .addr_o         (addr_o),
        .wdata_o        (wdata_o),
        .wstrb_o        (wstrb_o),
        .is_lr_o        (is_lr_o),
        .is_sc_o        (is_sc_o),
        .rdata_i        (rdata_i),
        .stall_i        (stall_i)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Response monitor: every pulse must match the oldest expectation, including its latency
    always @(negedge clk_i) begin
        if (!rst_i && resp_valid_o) begin
            if (resp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp: got data 0x%08h err %0d with nothing expected",
                         resp_data_o, resp_err_o);
            end else begin
                exp_resp_t e;
                e = resp_q.pop_front();
                chk({e.name, ".data"}, resp_data_o, e.data);
                chk({e.name, ".err"}, {30'd0, resp_err_o}, {30'd0, e.err});
                chk({e.name, ".lat"}, cyc - e.acc_cyc, e.lat);
            end
        end
    end

    // Bus monitor: any cycle with addr_o != 0 must match the oldest expected bus request
    always @(negedge clk_i) begin
        if (!rst_i && (addr_o != 32'd0)) begin
            if (bus_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_bus: got addr 0x%08h re %0b we %0b with nothing expected",
                         addr_o, re_o, we_o);
            end else begin
                exp_bus_t b;
                b = bus_q.pop_front();
                chk({b.name, ".addr"}, addr_o, b.addr);
                chk({b.name, ".rewe"}, {30'd0, re_o, we_o}, {30'd0, b.re, b.we});
                chk({b.name, ".wdata"}, wdata_o, b.wdata);
                chk({b.name, ".wstrb"}, {28'd0, wstrb_o}, {28'd0, b.wstrb});
                chk({b.name, ".lrsc"}, {30'd0, is_lr_o, is_sc_o}, {30'd0, b.lr, b.sc});
            end
        end else if (!rst_i && (re_o || we_o || is_lr_o || is_sc_o || (wstrb_o != 4'd0))) begin
            checks++;
            errors++;
            $display("FAIL stray_bus: re %0b we %0b lr %0b sc %0b wstrb %b with addr_o 0",
                     re_o, we_o, is_lr_o, is_sc_o, wstrb_o);
        end
    end

    // Present one request and play the bus side. nstall<0 marks a request rejected by the checks.
    task automatic send(input string name, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [1:0] size, input logic uns,
                        input logic lr, input logic sc, input int nstall, input logic [31:0] rdata,
                        input logic [31:0] exp_data, input logic [1:0] exp_err, input int exp_lat,
                        input logic [31:0] exp_wdata, input logic [3:0] exp_wstrb);
        int n;
        exp_resp_t e;
        exp_bus_t  b;
        req_valid_i    = 1'b1;
        req_we_i       = we;
        req_addr_i     = addr;
        req_wdata_i    = wdata;
        req_size_i     = size;
        req_unsigned_i = uns;
        req_lr_i       = lr;
        req_sc_i       = sc;
        n = 0;
        @(negedge clk_i);
        while (!req_ready_o && (n < 64)) begin
            @(negedge clk_i);
            n++;
        end
        if (n >= 64) begin
            checks++;
            errors++;
            $display("FAIL %s.accept: req_ready_o stayed low for %0d cycles, limit 64", name, n);
            req_valid_i = 1'b0;
            return;
        end
        @(posedge clk_i);
        #1;
        req_valid_i = 1'b0;
        req_addr_i  = $urandom;
        req_wdata_i = $urandom;
        e.data = exp_data; e.err = exp_err; e.acc_cyc = cyc; e.lat = exp_lat; e.name = name;
        resp_q.push_back(e);
        if (nstall >= 0) begin
            b.re = !we; b.we = we; b.addr = {addr[31:2], 2'b00}; b.wdata = exp_wdata;
            b.wstrb = exp_wstrb; b.lr = lr; b.sc = sc; b.name = name;
            bus_q.push_back(b);
            @(posedge clk_i);
            #1;
            for (int i = 0; i < nstall; i++) begin
                stall_i = 1'b1;
                rdata_i = $urandom;
                if (i == 12) chk({name, ".drain_ready"}, {31'd0, req_ready_o}, 32'd0);
                @(posedge clk_i);
                #1;
            end
            stall_i = 1'b0;
            rdata_i = rdata;
            @(posedge clk_i);
            #1;
            rdata_i = $urandom;
            chk({name, ".ready_after"}, {31'd0, req_ready_o}, 32'd1);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst.ready", {31'd0, req_ready_o}, 32'd1);
        chk("rst.resp_valid", {31'd0, resp_valid_o}, 32'd0);
        chk("rst.resp_data", resp_data_o, 32'd0);
        chk("rst.addr", addr_o, 32'd0);
        chk("rst.bus_ctl", {26'd0, re_o, we_o, wstrb_o}, 32'd0);
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;

        //   name        we    addr       wdata         sz  uns lr sc stall rdata         exp_data      err lat exp_wdata     wstrb
        send("ld_word",  1'b0, 32'h100, 32'h0,        2'd2, 0, 0, 0, 3,  32'hDEADBEEF, 32'hDEADBEEF, 2'd0, 5, 32'h0,        4'b1111);
        send("ld_b_s",   1'b0, 32'h103, 32'h0,        2'd0, 0, 0, 0, 1,  32'h80123456, 32'hFFFFFF80, 2'd0, 3, 32'h0,        4'b1000);
        send("ld_b_u",   1'b0, 32'h103, 32'h0,        2'd0, 1, 0, 0, 1,  32'h80123456, 32'h00000080, 2'd0, 3, 32'h0,        4'b1000);
        send("ld_h_s",   1'b0, 32'h102, 32'h0,        2'd1, 0, 0, 0, 2,  32'h80017F00, 32'hFFFF8001, 2'd0, 4, 32'h0,        4'b1100);
        send("st_half",  1'b1, 32'h102, 32'h1234ABCD, 2'd1, 0, 0, 0, 2,  32'h5A5A5A5A, 32'h0,        2'd0, 4, 32'hABCDABCD, 4'b1100);
        send("st_byte",  1'b1, 32'h101, 32'h000000AB, 2'd0, 0, 0, 0, 0,  32'h12345678, 32'h0,        2'd0, 2, 32'hABABABAB, 4'b0010);
        // Rejected requests, issued back to back with no bus traffic
        send("e_word",   1'b0, 32'h101, 32'h0,        2'd2, 0, 0, 0, -1, 32'h0,        32'h0,        2'd1, 0, 32'h0,        4'b0000);
        send("e_null",   1'b0, 32'h002, 32'h0,        2'd0, 0, 0, 0, -1, 32'h0,        32'h0,        2'd2, 0, 32'h0,        4'b0000);
        send("e_size3",  1'b0, 32'h100, 32'h0,        2'd3, 0, 0, 0, -1, 32'h0,        32'h0,        2'd1, 0, 32'h0,        4'b0000);
        send("e_half",   1'b1, 32'h103, 32'h0,        2'd1, 0, 0, 0, -1, 32'h0,        32'h0,        2'd1, 0, 32'h0,        4'b0000);
        send("e_mis_nul",1'b0, 32'h001, 32'h0,        2'd2, 0, 0, 0, -1, 32'h0,        32'h0,        2'd1, 0, 32'h0,        4'b0000);
        // Reservation pair, then an illegal-size SC
        send("lr",       1'b0, 32'h200, 32'h0,        2'd2, 0, 1, 0, 1,  32'h00000055, 32'h00000055, 2'd0, 3, 32'h0,        4'b1111);
        send("sc",       1'b1, 32'h200, 32'hCAFEF00D, 2'd2, 0, 0, 1, 1,  32'h00000000, 32'h00000000, 2'd0, 3, 32'hCAFEF00D, 4'b1111);
        send("sc_fail",  1'b1, 32'h204, 32'h1,        2'd2, 0, 0, 1, 0,  32'h00000001, 32'h00000001, 2'd0, 2, 32'h1,        4'b1111);
        send("e_sc_sz",  1'b1, 32'h200, 32'h0,        2'd0, 0, 0, 1, -1, 32'h0,        32'h0,        2'd1, 0, 32'h0,        4'b0000);
        // Stall outlasts the 8-cycle limit: timeout response, then drain with ready low
        send("timeout",  1'b0, 32'h300, 32'h0,        2'd2, 0, 0, 0, 20, 32'hFFFFFFFF, 32'h0,        2'd3, 9, 32'h0,        4'b1111);
        // Completion on the same cycle the limit is reached beats the timeout
        send("to_edge",  1'b0, 32'h304, 32'h0,        2'd2, 0, 0, 0, 7,  32'h0BADF00D, 32'h0BADF00D, 2'd0, 9, 32'h0,        4'b1111);

        // Reset during WAIT abandons the access without a response
        begin
            exp_bus_t b;
            req_valid_i = 1'b1; req_we_i = 1'b0; req_addr_i = 32'h400; req_size_i = 2'd2;
            req_unsigned_i = 1'b0; req_lr_i = 1'b0; req_sc_i = 1'b0; req_wdata_i = 32'h0;
            b.re = 1'b1; b.we = 1'b0; b.addr = 32'h400; b.wdata = 32'h0; b.wstrb = 4'b1111;
            b.lr = 1'b0; b.sc = 1'b0; b.name = "rst_mid";
            bus_q.push_back(b);
            @(posedge clk_i);
            #1;
            req_valid_i = 1'b0;
            @(posedge clk_i);
            #1;
            stall_i = 1'b1;
            @(posedge clk_i);
            #1;
            rst_i = 1'b1;
            @(posedge clk_i);
            #1;
            chk("rst_mid.ready", {31'd0, req_ready_o}, 32'd1);
            chk("rst_mid.resp_valid", {31'd0, resp_valid_o}, 32'd0);
            chk("rst_mid.bus", {26'd0, re_o, we_o, wstrb_o}, 32'd0);
            chk("rst_mid.addr", addr_o, 32'd0);
            rst_i   = 1'b0;
            stall_i = 1'b0;
            rdata_i = 32'h77777777;
            repeat (3) @(posedge clk_i);
            #1;
        end

        send("post_rst", 1'b0, 32'h104, 32'h0,        2'd2, 0, 0, 0, 1,  32'h12345678, 32'h12345678, 2'd0, 3, 32'h0,        4'b1111);

        repeat (4) @(posedge clk_i);
        #1;
        chk("resp_q_empty", resp_q.size(), 32'd0);
        chk("bus_q_empty", bus_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded 200000 time units");
        $fatal(1, "watchdog");
    end

endmodule
